// File: rtl/stream_burst_writer_if.sv
// Bus bundle between stream_burst_writer and its neighbours: the incoming
// word stream, the SDRAM write-port handshake and the status outputs.
//
// Handshake semantics:
//   Stream side: a word on s32 is offered for exactly the cycles where
//   n32rdy=1. It is taken on that clock edge only when en=1. There is no
//   back-pressure, so a word that cannot be buffered is lost.
//   SDRAM side: wr_req rises with a stable wr_addr and stays high until the
//   controller pulses wr_ack. Starting the cycle after that edge, wr_data
//   carries BURST_LEN words on consecutive cycles, each flagged by
//   wr_data_en=1.
interface stream_burst_writer_if #(
  parameter int ADDR_W = 22,
  parameter int LVL_W  = 5
);
  logic              en;
  logic [31:0]       s32;
  logic              n32rdy;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_data_en;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              busy;
  logic [15:0]       seq_err_cnt;

  modport master (
    input  en, s32, n32rdy, wr_ack,
    output wr_req, wr_addr, wr_data, wr_data_en, fifo_level, overflow, busy,
           seq_err_cnt
  );

  modport slave (
    output en, s32, n32rdy, wr_ack,
    input  wr_req, wr_addr, wr_data, wr_data_en, fifo_level, overflow, busy,
           seq_err_cnt
  );
endinterface

// File: rtl/stream_burst_writer.sv
// stream_burst_writer: buffers the 32-bit word stream in a FIFO and drains
// it as fixed-length write bursts to the SDRAM controller. The write address
// starts at 0 and advances by BURST_LEN after each burst, wrapping modulo
// 2^ADDR_W.
// Optional feature: define STREAM_CHECK_EN to count accepted words that are
// not the previous accepted word + 1. Without it seq_err_cnt is tied to 0.
module stream_burst_writer #(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_burst_writer_if.master bus,
  output logic [1:0]            state_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_q, rd_ptr_q, level;
  logic              full, push_req, push, pop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic              wr_req_q, wr_req_d;
  logic              wr_data_en_q, wr_data_en_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       seq_err_cnt;

  // FIFO occupancy and push acceptance; a pop in the same edge frees a slot
  always_comb begin
    level      = wr_ptr_q - rd_ptr_q;
    full       = (level == LVL_FULL);
    push_req   = bus.en & bus.n32rdy;
    push       = push_req & (~full | pop);
    overflow_d = overflow_q | (push_req & ~push);
  end

  // Burst FSM: next state, pop strobe and next values of registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    wr_req_d     = wr_req_q;
    wr_data_en_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.en && (level >= LVL_BURST)) begin
          state_d   = S_REQ;
          wr_req_d  = 1'b1;
          wr_addr_d = addr_q;
        end
      end
      S_REQ: begin
        // The first word is popped on the acking edge so it appears next cycle
        if (bus.wr_ack) begin
          state_d      = S_BURST;
          wr_req_d     = 1'b0;
          pop          = 1'b1;
          wr_data_en_d = 1'b1;
          cnt_d        = CNT_W'(1);
        end
      end
      S_BURST: begin
        if (cnt_q < CNT_LAST) begin
          pop          = 1'b1;
          wr_data_en_d = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          addr_d  = addr_q + ADDR_STEP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_data_d = pop ? mem_q[rd_ptr_q[PTR_W-1:0]] : wr_data_q;
  end

  // State, pointers and registered outputs; reset aborts any burst at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_req_q     <= 1'b0;
      wr_data_en_q <= 1'b0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_req_q     <= wr_req_d;
      wr_data_en_q <= wr_data_en_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + LVL_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LVL_W'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.s32;
  end

`ifdef STREAM_CHECK_EN
  logic [31:0] ref_q;
  logic        ref_vld_q;
  logic [15:0] seq_cnt_q, seq_cnt_d;

  // Count accepted words that break the +1 sequence, saturating
  always_comb begin
    seq_cnt_d = seq_cnt_q;
    if (push && ref_vld_q && (bus.s32 != ref_q + 32'd1) && (seq_cnt_q != 16'hFFFF))
      seq_cnt_d = seq_cnt_q + 16'd1;
  end

  // Reference tracks only accepted words; dropped words leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      seq_cnt_q <= '0;
    end else if (push) begin
      ref_q     <= bus.s32;
      ref_vld_q <= 1'b1;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign seq_err_cnt = seq_cnt_q;
`else
  assign seq_err_cnt = 16'd0;
`endif

  assign bus.wr_req      = wr_req_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_data_en  = wr_data_en_q;
  assign bus.fifo_level  = level;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.seq_err_cnt = seq_err_cnt;
  assign state_o         = state_q;
endmodule

// File: tb/tb_stream_burst_writer.sv
// Testbench for stream_burst_writer. Two instances share one stimulus: one
// with a 22-bit address and one with a 4-bit address to exercise wrapping.
// A queue-based model predicts every output each cycle; directed sequences
// add hand-computed literal expectations.
module tb_stream_burst_writer;
  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 8;
  localparam int LVL_W     = 5;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        en     = 1'b0;
  logic        n32rdy = 1'b0;
  logic        wr_ack = 1'b0;
  logic [31:0] s32    = 32'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  stream_burst_writer_if #(.ADDR_W(22), .LVL_W(LVL_W)) bus ();
  stream_burst_writer_if #(.ADDR_W(4),  .LVL_W(LVL_W)) bus_w ();

  assign bus.en       = en;
  assign bus.s32      = s32;
  assign bus.n32rdy   = n32rdy;
  assign bus.wr_ack   = wr_ack;
  assign bus_w.en     = en;
  assign bus_w.s32    = s32;
  assign bus_w.n32rdy = n32rdy;
  assign bus_w.wr_ack = wr_ack;

  logic [1:0] state_dbg, state_dbg_w;

  stream_burst_writer #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .ADDR_W(22)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
  );

  stream_burst_writer #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .ADDR_W(4)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w), .state_o(state_dbg_w)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_REQ, P_XFER} phase_t;
  phase_t      m_phase;
  logic [31:0] exp_q [$];
  int          m_beats;
  int          m_bursts;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_den;
  logic [31:0] m_data;
  logic        m_ovf;
  logic [15:0] m_seq;
`ifdef STREAM_CHECK_EN
  logic [31:0] m_ref;
  logic        m_ref_vld;
`endif

  function automatic void model_reset();
    m_phase  = P_IDLE;
    exp_q.delete();
    m_beats  = 0;
    m_bursts = 0;
    m_req    = 1'b0;
    m_addr   = 32'd0;
    m_den    = 1'b0;
    m_data   = 32'd0;
    m_ovf    = 1'b0;
    m_seq    = 16'd0;
`ifdef STREAM_CHECK_EN
    m_ref     = 32'd0;
    m_ref_vld = 1'b0;
`endif
  endfunction

  // Advance the model across the next rising edge, using the inputs that
  // edge will sample. Burst k starts at address k*BURST_LEN; word j of a
  // burst is the j-th oldest buffered word and appears j cycles after ack.
  function automatic void model_step();
    logic do_pop;
    do_pop = 1'b0;
    m_den  = 1'b0;
    case (m_phase)
      P_IDLE: if (en && exp_q.size() >= BURST_LEN) begin
        m_phase = P_REQ;
        m_req   = 1'b1;
        m_addr  = 32'(m_bursts * BURST_LEN);
      end
      P_REQ: if (wr_ack) begin
        m_phase = P_XFER;
        m_req   = 1'b0;
        m_beats = 0;
        do_pop  = 1'b1;
      end
      P_XFER: begin
        if (m_beats < BURST_LEN) do_pop = 1'b1;
        else begin
          m_phase = P_IDLE;
          m_bursts++;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    if (do_pop) begin
      m_data = exp_q.pop_front();
      m_den  = 1'b1;
      m_beats++;
    end
    if (en && n32rdy) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(s32);
`ifdef STREAM_CHECK_EN
        if (m_ref_vld && (s32 != m_ref + 32'd1) && (m_seq != 16'hFFFF)) m_seq++;
        m_ref     = s32;
        m_ref_vld = 1'b1;
`endif
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void model_compare();
    logic busy_exp;
    busy_exp = (m_phase != P_IDLE);
    check("wr_req",       bus.wr_req,       m_req);
    check("wr_req_w",     bus_w.wr_req,     m_req);
    check("wr_data_en",   bus.wr_data_en,   m_den);
    check("wr_data_en_w", bus_w.wr_data_en, m_den);
    check("fifo_level",   bus.fifo_level,   exp_q.size());
    check("fifo_level_w", bus_w.fifo_level, exp_q.size());
    check("overflow",     bus.overflow,     m_ovf);
    check("overflow_w",   bus_w.overflow,   m_ovf);
    check("busy",         bus.busy,         busy_exp);
    check("busy_w",       bus_w.busy,       busy_exp);
    check("seq_err_cnt",  bus.seq_err_cnt,  m_seq);
    if (m_den) begin
      check("wr_data",   bus.wr_data,   m_data);
      check("wr_data_w", bus_w.wr_data, m_data);
    end
    if (m_req) begin
      check("wr_addr",   bus.wr_addr,   m_addr[21:0]);
      check("wr_addr_w", bus_w.wr_addr, m_addr[3:0]);
    end
  endfunction

  // Compare process: on every falling edge check outputs, then predict
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      model_compare();
      if (!rst) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] cap_d [BURST_LEN];
  logic [21:0] cap_a;
  logic [3:0]  cap_aw;
  logic [3:0]  wrap_a [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input int gap);
    s32    = d;
    n32rdy = 1'b1;
    tick();
    n32rdy = 1'b0;
    repeat (gap) tick();
  endtask

  // Wait for a request, ack it two cycles later (optionally pushing a word
  // on the acking edge), then capture the burst's address and data.
  task automatic run_burst(input bit pwa, input logic [31:0] pd);
    int n;
    n = 0;
    while (bus.wr_req !== 1'b1 && n < 100) begin tick(); n++; end
    check("req_timeout", bus.wr_req, 1'b1);
    cap_a  = bus.wr_addr;
    cap_aw = bus_w.wr_addr;
    tick();
    wr_ack = 1'b1;
    if (pwa) begin
      s32    = pd;
      n32rdy = 1'b1;
    end
    tick();
    wr_ack = 1'b0;
    n32rdy = 1'b0;
    if (pwa) begin
      check("t4_level_at_full_push", bus.fifo_level, 16);
      check("t4_overflow_clear",     bus.overflow,   1'b0);
    end
    n = 0;
    while (bus.wr_data_en !== 1'b1 && n < 10) begin tick(); n++; end
    check("burst_start_timeout", bus.wr_data_en, 1'b1);
    for (int i = 0; i < BURST_LEN; i++) begin
      cap_d[i] = bus.wr_data;
      tick();
    end
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    int n;
    repeat (3) tick();
    check("rst_wr_req",     bus.wr_req,      1'b0);
    check("rst_wr_data_en", bus.wr_data_en,  1'b0);
    check("rst_level",      bus.fifo_level,  0);
    check("rst_overflow",   bus.overflow,    1'b0);
    check("rst_busy",       bus.busy,        1'b0);
    check("rst_wr_addr",    bus.wr_addr,     0);
    check("rst_seq",        bus.seq_err_cnt, 0);
    rst = 1'b0;
    tick();

    // Single burst, one word every 3 clocks
    en = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'hfafbfcfd + 32'(i), 2);
    run_burst(1'b0, 32'd0);
    check("t2_addr", cap_a, 0);
    for (int i = 0; i < 8; i++) check("t2_data", cap_d[i], 32'hfafbfcfd + 32'(i));
    wrap_a[0] = cap_aw;
    repeat (2) tick();

    // Overflow: 17 words with no ack; the 17th is lost
    for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i), 0);
    check("t3_level",    bus.fifo_level, 16);
    check("t3_overflow", bus.overflow,   1'b1);
    run_burst(1'b0, 32'd0);
    check("t3_addr1", cap_a, 8);
    for (int i = 0; i < 8; i++) check("t3_data1", cap_d[i], 32'h100 + 32'(i));
    wrap_a[1] = cap_aw;
    run_burst(1'b0, 32'd0);
    check("t3_addr2", cap_a, 16);
    for (int i = 0; i < 8; i++) check("t3_data2", cap_d[i], 32'h108 + 32'(i));
    wrap_a[2] = cap_aw;
    tick();
    check("t3_level_empty", bus.fifo_level, 0);

    // Address wrap on the 4-bit instance
    check("t5_wrap0", wrap_a[0], 0);
    check("t5_wrap1", wrap_a[1], 8);
    check("t5_wrap2", wrap_a[2], 0);

    // Reset in the middle of a burst
    for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i), 0);
    n = 0;
    while (bus.wr_req !== 1'b1 && n < 100) begin tick(); n++; end
    check("t1_req_timeout", bus.wr_req, 1'b1);
    tick();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    repeat (3) tick();
    check("t1_mid_burst", bus.wr_data_en, 1'b1);
    rst = 1'b1;
    #1;
    check("t1_wr_req",       bus.wr_req,       1'b0);
    check("t1_wr_data_en",   bus.wr_data_en,   1'b0);
    check("t1_level",        bus.fifo_level,   0);
    check("t1_overflow",     bus.overflow,     1'b0);
    check("t1_busy",         bus.busy,         1'b0);
    check("t1_wr_data_en_w", bus_w.wr_data_en, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Push at full while the burst pops on the same edge
    for (int i = 0; i < 16; i++) push_word(32'h300 + 32'(i), 0);
    check("t4_level_full", bus.fifo_level, 16);
    run_burst(1'b1, 32'h310);
    check("t4_addr1", cap_a, 0);
    for (int i = 0; i < 8; i++) check("t4_data1", cap_d[i], 32'h300 + 32'(i));
    run_burst(1'b0, 32'd0);
    check("t4_addr2", cap_a, 8);
    for (int i = 0; i < 8; i++) check("t4_data2", cap_d[i], 32'h308 + 32'(i));
    check("t4_level_left", bus.fifo_level, 1);
    for (int i = 1; i < 8; i++) push_word(32'h310 + 32'(i), 0);
    run_burst(1'b0, 32'd0);
    check("t4_addr3", cap_a, 16);
    for (int i = 0; i < 8; i++) check("t4_data3", cap_d[i], 32'h310 + 32'(i));
    check("t4_overflow_end", bus.overflow, 1'b0);

    // Sequence checker and en=0 ignore
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    en = 1'b0;
    push_word(32'h55, 0);
    check("t6_en0_ignored", bus.fifo_level, 0);
    en = 1'b1;
    push_word(32'd1, 0);
    push_word(32'd2, 0);
    push_word(32'd3, 0);
    push_word(32'd7, 0);
    push_word(32'd8, 0);
    check("t6_level", bus.fifo_level, 5);
`ifdef STREAM_CHECK_EN
    check("t6_seq_err_cnt", bus.seq_err_cnt, 1);
`else
    check("t6_seq_err_cnt", bus.seq_err_cnt, 0);
`endif
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
